// File: rtl/dbg_bridge_pkg.sv
// Shared types and constants for the host-byte-stream to debug-command bridge.
// The frame is CMD, ADDR (4 bytes, LSB first), DATA (4 bytes, LSB first); responses are 4 bytes, LSB first.
package dbg_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX_ADDR,
        RX_DATA,
        ISSUE,
        RESP
    } state_t;

    localparam logic [7:0] DBG_CMD_NOP      = 8'h00;
    localparam int         FRAME_ADDR_BYTES = 4;
    localparam int         FRAME_DATA_BYTES = 4;
    localparam int         RESP_BYTES       = 4;

    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/dbg_stream_bridge_if.sv
// Host byte link (rx/tx) plus the top-level debug command port, bundled for the bridge.
// A byte moves on a rising clk edge where valid and ready are both high; the source holds
// data and valid steady until that edge, and ready may depend on nothing but the sink's own state.
interface dbg_stream_bridge_if;

    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [7:0]  dbg_cmd_o;
    logic [31:0] dbg_addr_o;
    logic [31:0] dbg_data_o;
    logic [31:0] dbg_data_i;
    logic        dbg_ready_i;

    modport master (
        input  rx_data_i, rx_valid_i, tx_ready_i, dbg_data_i, dbg_ready_i,
        output rx_ready_o, tx_data_o, tx_valid_o, dbg_cmd_o, dbg_addr_o, dbg_data_o
    );

    modport slave (
        output rx_data_i, rx_valid_i, tx_ready_i, dbg_data_i, dbg_ready_i,
        input  rx_ready_o, tx_data_o, tx_valid_o, dbg_cmd_o, dbg_addr_o, dbg_data_o
    );

endinterface

// File: rtl/dbg_bridge_timeout.sv
// Loadable saturating down-counter: clear reloads LOAD_VALUE, enable counts toward zero,
// expired is high while the count sits at zero.
module dbg_bridge_timeout #(
    parameter int LOAD_VALUE = 15,
    parameter int CW         = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= CW'(LOAD_VALUE);
        end else if (enable && count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/dbg_stream_bridge.sv
// Turns 9-byte host frames into one debug command each and streams the 32-bit result back
// as 4 bytes; partial frames die after an idle gap, and stuck commands return ERR_WORD.
module dbg_stream_bridge
    import dbg_bridge_pkg::*;
#(
    parameter int          RX_GAP_CYCLES = 100000,
    parameter int          RESP_TIMEOUT  = 1024,
    parameter logic [31:0] ERR_WORD      = 32'hDEADBEEF
) (
    input  logic                 clk,
    input  logic                 rstn_i,
    dbg_stream_bridge_if.master  bus,
    output logic                 busy_o,
    output logic                 timeout_o,
    output state_t               state_o
);

    localparam int GAP_W  = $clog2(RX_GAP_CYCLES + 1);
    localparam int RESP_W = $clog2(RESP_TIMEOUT + 1);

    state_t      state;
    state_t      state_next;
    logic [7:0]  cmd_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [31:0] result_q;
    logic [1:0]  cnt_q;
    logic        rx_ready_q;
    logic [7:0]  dbg_cmd_q;
    logic        rx_fire;
    logic        tx_fire;
    logic        in_rx;
    logic        gap_expired;
    logic        resp_expired;

    assign rx_fire = bus.rx_valid_i & rx_ready_q;
    assign tx_fire = bus.tx_valid_o & bus.tx_ready_i;
    assign in_rx   = (state == RX_ADDR) || (state == RX_DATA);

    // Timers are loaded with N-1 so that expiry lands in the Nth counted cycle.
    dbg_bridge_timeout #(
        .LOAD_VALUE (RX_GAP_CYCLES - 1),
        .CW         (GAP_W)
    ) u_gap_timer (
        .clk     (clk),
        .rst_n   (rstn_i),
        .clear   (!in_rx || rx_fire),
        .enable  (in_rx),
        .expired (gap_expired)
    );

    dbg_bridge_timeout #(
        .LOAD_VALUE (RESP_TIMEOUT - 1),
        .CW         (RESP_W)
    ) u_resp_timer (
        .clk     (clk),
        .rst_n   (rstn_i),
        .clear   (state != ISSUE),
        .enable  (state == ISSUE),
        .expired (resp_expired)
    );

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        timeout_o  = 1'b0;
        case (state)
            IDLE: begin
                if (rx_fire && bus.rx_data_i != DBG_CMD_NOP) begin
                    state_next = RX_ADDR;
                end
            end
            RX_ADDR: begin
                if (rx_fire) begin
                    if (cnt_q == 2'(FRAME_ADDR_BYTES - 1)) begin
                        state_next = RX_DATA;
                    end
                end else if (gap_expired) begin
                    state_next = IDLE;
                end
            end
            RX_DATA: begin
                if (rx_fire) begin
                    if (cnt_q == 2'(FRAME_DATA_BYTES - 1)) begin
                        state_next = ISSUE;
                    end
                end else if (gap_expired) begin
                    state_next = IDLE;
                end
            end
            ISSUE: begin
                // A completion in the same cycle as expiry wins over the timeout.
                if (bus.dbg_ready_i) begin
                    state_next = RESP;
                end else if (resp_expired) begin
                    state_next = RESP;
                    timeout_o  = 1'b1;
                end
            end
            RESP: begin
                if (tx_fire && cnt_q == 2'(RESP_BYTES - 1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            cmd_q      <= DBG_CMD_NOP;
            addr_q     <= '0;
            data_q     <= '0;
            result_q   <= '0;
            cnt_q      <= '0;
            rx_ready_q <= 1'b0;
            dbg_cmd_q  <= DBG_CMD_NOP;
        end else begin
            // Registered from the next state so rx_ready_o stays low through reset.
            rx_ready_q <= (state_next == IDLE) || (state_next == RX_ADDR) ||
                          (state_next == RX_DATA);
            dbg_cmd_q  <= (state_next == ISSUE) ? cmd_q : DBG_CMD_NOP;
            case (state)
                IDLE: begin
                    if (rx_fire && bus.rx_data_i != DBG_CMD_NOP) begin
                        cmd_q <= bus.rx_data_i;
                        cnt_q <= '0;
                    end
                end
                RX_ADDR: begin
                    if (rx_fire) begin
                        addr_q[{cnt_q, 3'b000} +: 8] <= bus.rx_data_i;
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_fire) begin
                        data_q[{cnt_q, 3'b000} +: 8] <= bus.rx_data_i;
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                ISSUE: begin
                    cnt_q <= '0;
                    if (bus.dbg_ready_i) begin
                        result_q <= bus.dbg_data_i;
                    end else if (resp_expired) begin
                        result_q <= ERR_WORD;
                    end
                end
                RESP: begin
                    if (tx_fire) begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                default: cnt_q <= '0;
            endcase
        end
    end

    assign bus.rx_ready_o = rx_ready_q;
    assign bus.dbg_cmd_o  = dbg_cmd_q;
    assign bus.dbg_addr_o = addr_q;
    assign bus.dbg_data_o = data_q;
    assign bus.tx_valid_o = (state == RESP);
    assign bus.tx_data_o  = (state == RESP) ? word_byte(result_q, cnt_q) : 8'h00;
    assign busy_o         = (state != IDLE);
    assign state_o        = state;

endmodule

// File: doc/dbg_stream_bridge.md
Name: dbg_stream_bridge

Overview:
- Initiator for the debug command port (cmd/addr/data in, data/ready out) that the debug module exposes at the top level.
- Converts a byte stream from a host link (UART RX/TX or JTAG byte FIFO, valid/ready) into debug commands.
- For every executed command, returns the 32-bit debug result to the host as bytes.
- Sits between the host byte link and the top-level dbg_* pins.

Parameters:
- RX_GAP_CYCLES, 100000: maximum idle cycles between bytes of one frame before the frame is discarded.
- RESP_TIMEOUT, 1024: maximum cycles to wait for dbg_ready_i before the command is abandoned.
- ERR_WORD, 32'hDEADBEEF: word returned to the host on response timeout.

Ports:
- clk  in  1  system clock
- rstn_i  in  1  asynchronous active-low reset
- rx_data_i  in  8  host byte
- rx_valid_i  in  1  rx_data_i valid
- rx_ready_o  out  1  bridge accepts byte (transfer when valid & ready)
- tx_data_o  out  8  response byte
- tx_valid_o  out  1  tx_data_o valid
- tx_ready_i  in  1  host link accepts byte
- dbg_cmd_o  out  8  debug command (8'h00 = NOP)
- dbg_addr_o  out  32  debug address
- dbg_data_o  out  32  debug write data
- dbg_data_i  in  32  debug read data
- dbg_ready_i  in  1  debug command complete, single-cycle pulse
- busy_o  out  1  frame in progress (any state except IDLE)
- timeout_o  out  1  one-cycle pulse on response timeout

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous and active-low on rstn_i. All flops are cleared asynchronously.
- Reset values: rx_ready_o=0, tx_valid_o=0, tx_data_o=0, dbg_cmd_o=8'h00, dbg_addr_o=0, dbg_data_o=0, busy_o=0, timeout_o=0. The state machine resets to IDLE.
- Frame format, 9 bytes: CMD, ADDR[7:0], ADDR[15:8], ADDR[23:16], ADDR[31:24], DATA[7:0] through DATA[31:24]. Both fields are little-endian.
- Response format: 4 bytes, RES[7:0] first.
- IDLE: rx_ready_o=1.
  - Byte 8'h00 is accepted and dropped; this is the resync/NOP byte.
  - Any other byte is latched as cmd; byte counter cleared; go to RX_ADDR.
- RX_ADDR: rx_ready_o=1. Each accepted byte is shifted into addr at position counter*8. After the 4th byte, go to RX_DATA.
- RX_DATA: same as RX_ADDR, into data. After the 4th byte, go to ISSUE.
- Gap timer (RX_ADDR/RX_DATA only):
  - Counts cycles without an rx transfer and resets on each transfer.
  - On reaching RX_GAP_CYCLES, the partial frame is discarded and the state returns to IDLE.
  - No dbg command is issued and no response is sent.
- ISSUE:
  - rx_ready_o=0; dbg_cmd_o/dbg_addr_o/dbg_data_o driven from the latched frame.
  - All three are held stable until completion.
  - The response counter increments each cycle.
  - On dbg_ready_i=1: latch dbg_data_i into the result, set dbg_cmd_o=8'h00 in the next cycle, go to RESP.
  - If RESP_TIMEOUT cycles elapse without dbg_ready_i: result=ERR_WORD, dbg_cmd_o=8'h00, timeout_o pulses for 1 cycle, go to RESP.
  - dbg_ready_i outside ISSUE is ignored.
- RESP:
  - tx_valid_o=1 with tx_data_o=result byte[counter].
  - The counter advances on tx_valid_o & tx_ready_i.
  - tx_data_o and tx_valid_o are stable while tx_ready_i=0.
  - After the 4th byte is accepted, tx_valid_o=0 and the state returns to IDLE.
- Latency:
  - The cycle after the 9th rx byte is accepted, dbg_cmd_o is nonzero.
  - The first tx byte is valid the cycle after dbg_ready_i.
  - Back-to-back frames are accepted once IDLE is re-entered (no extra bubble).
- No rx byte is accepted during ISSUE/RESP (rx_ready_o=0); the host must wait for the response.
- Reset mid-operation: everything returns immediately to reset values. A held dbg_cmd_o drops to 0 asynchronously.
- Counters: byte counter 2 bits. Gap and response counters are sized $clog2(param+1) and saturate; they never wrap.

Decomposition:
- Package dbg_bridge_pkg holds:
  - state enum: IDLE, RX_ADDR, RX_DATA, ISSUE, RESP;
  - DBG_CMD_NOP = 8'h00;
  - FRAME_ADDR_BYTES = 4, FRAME_DATA_BYTES = 4, RESP_BYTES = 4.
- One natural sub-module, dbg_bridge_timeout: a loadable saturating down-counter with clear/enable inputs and an expired output.
  - Instantiated twice: once for the rx gap, once for the response timeout.

Test Plan:
- Frame 01 00 08 00 00 78 56 34 12 with dbg_ready_i pulsed 5 cycles after issue:
  - dbg_cmd_o=01, dbg_addr_o=32'h800, dbg_data_o=32'h12345678 held until ready.
  - dbg_data_i=32'hCAFEF00D returns bytes 0D F0 FE CA.
- Leading 00 00 bytes then a valid frame: the NOPs are dropped, the frame executes normally, exactly one response is sent.
- Frame with dbg_ready_i never asserted, RESP_TIMEOUT=16:
  - timeout_o pulses at cycle 16 of ISSUE; dbg_cmd_o returns to 0.
  - Response is EF BE AD DE.
- 5 bytes sent, then idle for RX_GAP_CYCLES (set to 20):
  - Returns to IDLE, dbg_cmd_o stays 0, no tx output.
  - The next full frame executes correctly.
- tx_ready_i toggled randomly during RESP: all 4 bytes are delivered in order, with tx_data_o stable while stalled.
- rstn_i asserted during ISSUE: dbg_cmd_o=0 and tx_valid_o=0 immediately. After release, rx_ready_o=1 and a new frame executes.
